// File: rtl/imm_decode_stage_pkg.sv
// Shared RV32I/RV64I decode definitions: base opcodes, immediate format codes and the
// XLEN legality check used by the immediate-decode stage.
package imm_decode_stage_pkg;

  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpMiscMem = 7'b0001111;
  localparam logic [6:0] OpOpImm   = 7'b0010011;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpOp      = 7'b0110011;
  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpSystem  = 7'b1110011;

  typedef enum logic [2:0] {
    FmtR    = 3'd0,
    FmtI    = 3'd1,
    FmtS    = 3'd2,
    FmtB    = 3'd3,
    FmtU    = 3'd4,
    FmtJ    = 3'd5,
    FmtSh   = 3'd6,
    FmtNone = 3'd7
  } fmt_e;

  function automatic bit width_ok(int unsigned w);
    return (w == 32) || (w == 64);
  endfunction

endpackage

// File: rtl/rv_imm_extract.sv
// Combinational immediate extractor: maps a raw instruction to its sign-extended immediate,
// format code and illegal flag for XLEN = WIDTH.
module rv_imm_extract
  import imm_decode_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [31:0]      instr_i,
  output logic [WIDTH-1:0] imm_o,
  output fmt_e             fmt_o,
  output logic             illegal_o
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("rv_imm_extract: WIDTH must be 32 or 64");
  end

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_shift;
  logic       sh_ok;

  assign opcode   = instr_i[6:0];
  assign funct3   = instr_i[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // RV64 steals bit 25 for shamt[5], so only bits 31:26 remain as the funct field.
  always_comb begin
    if (WIDTH == 64) begin
      sh_ok = (instr_i[31:26] == 6'b000000) ||
              ((funct3 == 3'b101) && (instr_i[31:26] == 6'b010000));
    end else begin
      sh_ok = (instr_i[31:25] == 7'b0000000) ||
              ((funct3 == 3'b101) && (instr_i[31:25] == 7'b0100000));
    end
  end

  always_comb begin
    imm_o     = '0;
    fmt_o     = FmtNone;
    illegal_o = 1'b0;
    unique case (opcode)
      OpLoad, OpJalr, OpMiscMem, OpSystem: fmt_o = FmtI;
      OpOpImm:                             fmt_o = is_shift ? FmtSh : FmtI;
      OpStore:                             fmt_o = FmtS;
      OpBranch:                            fmt_o = FmtB;
      OpLui, OpAuipc:                      fmt_o = FmtU;
      OpJal:                               fmt_o = FmtJ;
      OpOp:                                fmt_o = FmtR;
      default:                             illegal_o = 1'b1;
    endcase

    // Fill with the sign bit first, then overwrite the low-order field.
    unique case (fmt_o)
      FmtI: begin
        imm_o        = {WIDTH{instr_i[31]}};
        imm_o[11:0]  = instr_i[31:20];
      end
      FmtS: begin
        imm_o        = {WIDTH{instr_i[31]}};
        imm_o[11:0]  = {instr_i[31:25], instr_i[11:7]};
      end
      FmtB: begin
        imm_o        = {WIDTH{instr_i[31]}};
        imm_o[12:0]  = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
      end
      FmtU: begin
        imm_o        = {WIDTH{instr_i[31]}};
        imm_o[31:0]  = {instr_i[31:12], 12'b0};
      end
      FmtJ: begin
        imm_o        = {WIDTH{instr_i[31]}};
        imm_o[20:0]  = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
      end
      FmtSh: begin
        if (WIDTH == 64) imm_o[5:0] = instr_i[25:20];
        else             imm_o[4:0] = instr_i[24:20];
        illegal_o = ~sh_ok;
      end
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with a 2-entry skid buffer (main + skid) so the stage
// sustains full throughput while in_ready stays a pure register output.
module imm_decode_stage
  import imm_decode_stage_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned PC_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [PC_W-1:0]  out_pc,
  output logic [WIDTH-1:0] out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal
);

  localparam int unsigned PayW = 32 + PC_W + WIDTH + 3 + 1;
  localparam logic [PayW-1:0] PayRst = {{(PayW - 4){1'b0}}, 3'd7, 1'b0};

  logic [WIDTH-1:0] dec_imm;
  fmt_e             dec_fmt;
  logic             dec_illegal;

  rv_imm_extract #(
    .WIDTH (WIDTH)
  ) u_extract (
    .instr_i   (in_instr),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_illegal)
  );

  logic [PayW-1:0] in_pay;
  logic [PayW-1:0] main_q, main_d, skid_q, skid_d;
  logic            main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic            accept, drain;

  assign in_pay = {in_instr, in_pc, dec_imm, dec_fmt, dec_illegal};
  assign accept = in_valid & ~skid_valid_q & ~flush;
  assign drain  = main_valid_q & out_ready;

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (drain || !main_valid_q) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = in_pay;
      end
    end else if (accept) begin
      skid_d       = in_pay;
      skid_valid_d = 1'b1;
    end
    // Flush only invalidates; payload registers keep their contents.
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= PayRst;
      skid_q       <= PayRst;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign {out_instr, out_pc, out_imm, out_fmt, out_illegal} = main_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: decode vectors at WIDTH=32 and 64, back-pressure
// streaming, flush and mid-stream reset.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_instr, out_pc, out_imm;
  logic [2:0]  out_fmt;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [31:0] out_instr64, out_pc64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.WIDTH(32), .PC_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_imm     (out_imm),
    .out_fmt     (out_fmt),
    .out_illegal (out_illegal)
  );

  imm_decode_stage #(.WIDTH(64), .PC_W(32)) dut64 (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready64),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid64),
    .out_ready   (out_ready),
    .out_instr   (out_instr64),
    .out_pc      (out_pc64),
    .out_imm     (out_imm64),
    .out_fmt     (out_fmt64),
    .out_illegal (out_illegal64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction with out_ready=1; it must appear on out_* one cycle later.
  task automatic dec(input string tag, input logic [31:0] ins, input logic [31:0] imm,
                     input logic [2:0] fmt, input logic ill);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = in_pc + 32'd4;
    tick();
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_instr"}, out_instr, ins);
    chk({tag, "_pc"}, out_pc, in_pc);
    chk({tag, "_imm"}, out_imm, imm);
    chk({tag, "_fmt"}, out_fmt, fmt);
    chk({tag, "_ill"}, out_illegal, ill);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_rdy"}, in_ready, 1'b1);
    chk({tag, "_imm"}, out_imm, 32'h0);
    chk({tag, "_instr"}, out_instr, 32'h0);
    chk({tag, "_pc"}, out_pc, 32'h0);
    chk({tag, "_fmt"}, out_fmt, 3'd7);
    chk({tag, "_ill"}, out_illegal, 1'b0);
    chk({tag, "_v64"}, out_valid64, 1'b0);
    chk({tag, "_rdy64"}, in_ready64, 1'b1);
    chk({tag, "_fmt64"}, out_fmt64, 3'd7);
  endtask

  logic [31:0] bp_q [8];
  int          tx, rx, occ;
  logic        fin, fout;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = 32'h0; in_pc = 32'h1000;
    tick();
    tick();
    chk_reset("rst");
    rst = 1'b0;

    dec("addi", 32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0);
    chk("addi64_imm", out_imm64, 64'hFFFFFFFF_FFFFFFFF);
    chk("addi64_instr", out_instr64, 32'hFFF00093);
    chk("addi64_pc", out_pc64, in_pc);
    dec("sw", 32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0);
    dec("beq", 32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0);
    dec("lui", 32'h123452B7, 32'h12345000, 3'd4, 1'b0);
    dec("jal", 32'h001000EF, 32'h00000800, 3'd5, 1'b0);
    dec("slli", 32'h00509093, 32'h5, 3'd6, 1'b0);
    dec("srai", 32'h4050D093, 32'h5, 3'd6, 1'b0);
    dec("badsh", 32'h02009093, 32'h0, 3'd6, 1'b1);
    chk("badsh64_imm", out_imm64, 64'h20);
    chk("badsh64_ill", out_illegal64, 1'b0);
    chk("badsh64_fmt", out_fmt64, 3'd6);
    dec("unk", 32'h0000007F, 32'h0, 3'd7, 1'b1);
    dec("lo2", 32'h00000010, 32'h0, 3'd7, 1'b1);
    dec("add", 32'h002081B3, 32'h0, 3'd0, 1'b0);
    dec("lui8", 32'h800002B7, 32'h80000000, 3'd4, 1'b0);
    chk("lui64_imm", out_imm64, 64'hFFFFFFFF_80000000);
    dec("i800", 32'h80000093, 32'hFFFFF800, 3'd1, 1'b0);
    chk("i800_64_imm", out_imm64, 64'hFFFFFFFF_FFFFF800);
    chk("i800_64_v", out_valid64, 1'b1);

    in_valid = 1'b0;
    tick();
    chk("drained", out_valid, 1'b0);

    // Back-pressure stream: out_ready follows 1,0,0 repeating.
    for (int i = 0; i < 8; i++) bp_q[i] = {12'(i + 1), 5'd0, 3'b000, 5'd1, 7'h13};
    tx = 0; rx = 0; occ = 0;
    for (int c = 0; c < 100 && rx < 8; c++) begin
      out_ready = (c % 3 == 0);
      in_valid  = (tx < 8);
      in_instr  = bp_q[(tx < 8) ? tx : 7];
      chk("bp_in_ready", in_ready, occ < 2);
      chk("bp_out_valid", out_valid, occ > 0);
      fin  = in_valid && in_ready;
      fout = out_valid && out_ready;
      if (fout) begin
        chk("bp_order", out_instr, bp_q[rx]);
        chk("bp_imm", out_imm, 32'(rx + 1));
        rx++;
      end
      tick();
      if (fin) begin tx++; occ++; end
      if (fout) occ--;
    end
    in_valid = 1'b0;
    chk("bp_count", rx, 8);
    out_ready = 1'b1;
    tick();

    // Flush with main and skid occupied and an input on offer.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;
    tick();
    in_instr = 32'h00200093;
    tick();
    chk("fl_skid_full", in_ready, 1'b0);
    chk("fl_main", out_instr, 32'h00100093);
    in_instr = 32'h00300093;
    flush    = 1'b1;
    tick();
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_rdy", in_ready, 1'b1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("fl_dropped", out_valid, 1'b0);
    dec("post_fl", 32'h00400093, 32'h4, 3'd1, 1'b0);

    // Reset in the middle of a stalled stream.
    out_ready = 1'b0;
    in_instr  = 32'h00500093;
    tick();
    chk("mid_valid", out_valid, 1'b1);
    in_instr = 32'h00600093;
    rst      = 1'b1;
    flush    = 1'b1;
    tick();
    chk_reset("mid_rst");
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
